// File: rtl/lut_layer_scheduler_if.sv
// Signal bundle between lut_layer_scheduler (master) and the layer fabric around it (slave):
// upstream vector handshake, gather mux, truth-table ROM port and downstream handshake.
interface lut_layer_scheduler_if #(
    parameter int N_NEURONS = 32,
    parameter int FANIN     = 4,
    parameter int IN_BITS   = 2,
    parameter int OUT_BITS  = 2,
    parameter int IN_VEC_W  = 64
);
    localparam int IDX_W  = $clog2(N_NEURONS);
    localparam int CODE_W = FANIN * IN_BITS;

    logic                          in_valid;
    logic                          in_ready;
    logic [IN_VEC_W-1:0]           in_data;
    logic [IN_VEC_W-1:0]           act_q;
    logic [IDX_W-1:0]              sel_idx;
    logic [CODE_W-1:0]             gather_in;
    logic                          rom_en;
    logic [IDX_W+CODE_W-1:0]       rom_addr;
    logic [OUT_BITS-1:0]           rom_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [N_NEURONS*OUT_BITS-1:0] out_data;
    logic                          busy;

    modport master (
        input  in_valid, in_data, gather_in, rom_data, out_ready,
        output in_ready, act_q, sel_idx, rom_en, rom_addr, out_valid, out_data, busy
    );

    modport slave (
        output in_valid, in_data, gather_in, rom_data, out_ready,
        input  in_ready, act_q, sel_idx, rom_en, rom_addr, out_valid, out_data, busy
    );
endinterface

// File: rtl/lut_layer_scheduler.sv
// Folds one LogicNets LUT layer onto a single shared truth-table ROM port, one neuron per cycle.
// Optional performance counters (stall_cnt, xact_cnt) are built when LUT_LAYER_SCHED_PERF_EN is defined.
module lut_layer_scheduler #(
    parameter int N_NEURONS = 32,
    parameter int FANIN     = 4,
    parameter int IN_BITS   = 2,
    parameter int OUT_BITS  = 2,
    parameter int IN_VEC_W  = 64,
    parameter int ROM_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lut_layer_scheduler_if.master bus
`ifdef LUT_LAYER_SCHED_PERF_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           xact_cnt
`endif
);
    localparam int IDX_W  = $clog2(N_NEURONS);
    localparam int CODE_W = FANIN * IN_BITS;
    localparam int OUT_W  = N_NEURONS * OUT_BITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e                            state_q, state_d;
    logic [IDX_W-1:0]                  selIdx_q, selIdx_d;
    logic [IN_VEC_W-1:0]               actData_q, actData_d;
    logic [OUT_W-1:0]                  outData_q, outData_d;
    logic [ROM_LAT-1:0]                pipeValid_q, pipeValid_d;
    logic [ROM_LAT-1:0][IDX_W-1:0]     pipeIdx_q, pipeIdx_d;

    logic                              inReady;
    logic                              romEn;
    logic                              outValid;
    logic                              busyFlag;
    logic                              retValid;
    logic [IDX_W-1:0]                  retIdx;

    // The oldest pipeline stage lines up with the ROM word that is arriving this cycle.
    assign retValid = pipeValid_q[ROM_LAT-1];
    assign retIdx   = pipeIdx_q[ROM_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        selIdx_d  = selIdx_q;
        actData_d = actData_q;
        inReady   = 1'b0;
        romEn     = 1'b0;
        outValid  = 1'b0;
        busyFlag  = 1'b1;
        case (state_q)
            IDLE: begin
                inReady  = 1'b1;
                busyFlag = 1'b0;
                if (bus.in_valid) begin
                    actData_d = bus.in_data;
                    selIdx_d  = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                romEn = 1'b1;
                // Terminal compare against the last index keeps non-power-of-two sizes in range.
                if (selIdx_q == LAST_IDX) begin
                    selIdx_d = '0;
                    state_d  = DRAIN;
                end else begin
                    selIdx_d = selIdx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (retValid && (retIdx == LAST_IDX)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                outValid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pipeValid_d    = '0;
        pipeIdx_d      = '0;
        pipeValid_d[0] = romEn;
        pipeIdx_d[0]   = selIdx_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            pipeValid_d[i] = pipeValid_q[i-1];
            pipeIdx_d[i]   = pipeIdx_q[i-1];
        end
    end

    always_comb begin
        outData_d = outData_q;
        if (retValid && ((state_q == ISSUE) || (state_q == DRAIN))) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                if (retIdx == IDX_W'(k)) begin
                    outData_d[k*OUT_BITS +: OUT_BITS] = bus.rom_data;
                end
            end
        end
    end

    // Clearing the return pipeline on reset discards any ROM reads still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selIdx_q    <= '0;
            actData_q   <= '0;
            outData_q   <= '0;
            pipeValid_q <= '0;
            pipeIdx_q   <= '0;
        end else begin
            selIdx_q    <= selIdx_d;
            actData_q   <= actData_d;
            outData_q   <= outData_d;
            pipeValid_q <= pipeValid_d;
            pipeIdx_q   <= pipeIdx_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.act_q     = actData_q;
    assign bus.sel_idx   = selIdx_q;
    assign bus.rom_en    = romEn;
    assign bus.rom_addr  = {selIdx_q, bus.gather_in};
    assign bus.out_valid = outValid;
    assign bus.out_data  = outData_q;
    assign bus.busy      = busyFlag;

`ifdef LUT_LAYER_SCHED_PERF_EN
    logic [31:0] stallCnt_q, stallCnt_d;
    logic [31:0] xactCnt_q, xactCnt_d;

    // Both counters saturate rather than wrap; they only observe the handshake.
    always_comb begin
        stallCnt_d = stallCnt_q;
        xactCnt_d  = xactCnt_q;
        if ((state_q == HOLD) && !bus.out_ready && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
        if ((state_q == HOLD) && bus.out_ready && (xactCnt_q != 32'hFFFF_FFFF)) begin
            xactCnt_d = xactCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
            xactCnt_q  <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            xactCnt_q  <= xactCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;
    assign xact_cnt  = xactCnt_q;
`endif

endmodule
